ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX pipeline register and the EX/MEM register and consumes the ID/EX register outputs. It computes the ALU result, the zero flag, the destination register and the branch target. It also owns the HI/LO registers and an iterative multi-cycle multiply/divide unit, and raises a stall toward IF/ID/ID-EX when a HI/LO access must wait.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/md_unit.sv | 139 +++++++++++++
 rtl/ex_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp codes, R-type funct values
// and the multiply/divide sequencer states.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Iterative 32-step multiply/divide unit owning HI/LO. op[1] selects divide,
// op[0] selects unsigned; results are written in FIX, 33 edges after start.
module md_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    md_state_e           state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   a_r, hi_r, lo_r;
    logic [2*DATA_W-1:0] p_r;
    logic                neg_q_r, neg_r_r, dz_r, div_r;
    logic                op_signed_s;
    logic [DATA_W-1:0]   a_mag_s, b_mag_s, quo_fix_s, rem_fix_s;
    logic [DATA_W:0]     mul_sum_s;
    logic [DATA_W+1:0]   div_diff_s;
    logic [2*DATA_W-1:0] mul_step_s, div_step_s, prod_fix_s;

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x);
        return ~x + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    assign op_signed_s = ~op[0];
    assign a_mag_s     = (op_signed_s && a[DATA_W-1]) ? neg_w(a) : a;
    assign b_mag_s     = (op_signed_s && b[DATA_W-1]) ? neg_w(b) : b;

    // p_r holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum_s  = {1'b0, p_r[2*DATA_W-1:DATA_W]} + (p_r[0] ? {1'b0, a_r} : {(DATA_W+1){1'b0}});
    assign mul_step_s = {mul_sum_s, p_r[DATA_W-1:1]};
    assign div_diff_s = {1'b0, p_r[2*DATA_W-1:DATA_W-1]} - {2'b00, a_r};
    assign div_step_s = div_diff_s[DATA_W+1] ? {p_r[2*DATA_W-2:0], 1'b0}
                                             : {div_diff_s[DATA_W-1:0], p_r[DATA_W-2:0], 1'b1};

    assign prod_fix_s = neg_q_r ? (~p_r + {{(2*DATA_W-1){1'b0}}, 1'b1}) : p_r;
    assign quo_fix_s  = neg_q_r ? neg_w(p_r[DATA_W-1:0]) : p_r[DATA_W-1:0];
    assign rem_fix_s  = neg_r_r ? neg_w(p_r[2*DATA_W-1:DATA_W]) : p_r[2*DATA_W-1:DATA_W];

    assign busy = (state_r != IDLE);
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Next-state logic for the sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = op[1] ? DIV : MUL;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (cnt_r == LAST_ITER) begin
                    state_s = FIX;
                end else begin
                    state_s = state_r;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration datapath and HI/LO write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= {DATA_W{1'b0}};
            p_r     <= {(2*DATA_W){1'b0}};
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
            div_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= b_mag_s;
                        p_r     <= {{DATA_W{1'b0}}, a_mag_s};
                        neg_q_r <= op_signed_s & (a[DATA_W-1] ^ b[DATA_W-1]);
                        neg_r_r <= op_signed_s & a[DATA_W-1];
                        dz_r    <= (b == {DATA_W{1'b0}});
                        div_r   <= op[1];
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                end
                MUL: begin
                    p_r   <= mul_step_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                DIV: begin
                    p_r   <= div_step_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    if (!div_r) begin
                        {hi_r, lo_r} <= prod_fix_s;
                    end else begin
                        // Divide by zero keeps the remainder (= A) and forces an all-ones quotient.
                        hi_r <= rem_fix_s;
                        lo_r <= dz_r ? {DATA_W{1'b1}} : quo_fix_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, destination select, branch target and HI/LO access
// control, with stall generation while the multiply/divide unit is busy.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              RegDstPipe,
    input  logic              ALUSrcPipe,
    input  logic              RegWritePipe,
    input  logic [1:0]        ALUOpPipe,
    input  logic [DATA_W-1:0] rfile_rd1Pipe,
    input  logic [DATA_W-1:0] rfile_rd2Pipe,
    input  logic [DATA_W-1:0] extend_immedPipe,
    input  logic [4:0]        rtPipe,
    input  logic [4:0]        rdPipe,
    input  logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] branch_target,
    output logic              ex_reg_write,
    output logic              ex_stall,
    output logic              md_busy
);
    logic [5:0]        funct_s;
    logic [4:0]        shamt_s;
    logic [DATA_W-1:0] op_b_s, hi_s, lo_s, result_s;
    logic              md_op_s, mt_op_s, mf_op_s, hilo_op_s, busy_s;

    assign funct_s = extend_immedPipe[5:0];
    assign shamt_s = extend_immedPipe[10:6];
    assign op_b_s  = ALUSrcPipe ? extend_immedPipe : rfile_rd2Pipe;

    // Classify valid R-type instructions that touch HI/LO.
    always_comb begin
        md_op_s = 1'b0;
        mt_op_s = 1'b0;
        mf_op_s = 1'b0;
        if (in_valid && (ALUOpPipe == ALUOP_RTYPE)) begin
            case (funct_s)
                F_MFHI, F_MFLO:                 mf_op_s = 1'b1;
                F_MTHI, F_MTLO:                 mt_op_s = 1'b1;
                F_MULT, F_MULTU, F_DIV, F_DIVU: md_op_s = 1'b1;
                default:                        md_op_s = 1'b0;
            endcase
        end else begin
            md_op_s = 1'b0;
        end
    end

    assign hilo_op_s    = md_op_s | mt_op_s | mf_op_s;
    assign ex_stall     = hilo_op_s & busy_s;
    assign ex_reg_write = in_valid & RegWritePipe & ~ex_stall & ~md_op_s & ~mt_op_s;
    assign md_busy      = busy_s;

    md_unit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_op_s & ~ex_stall),
        .op    (funct_s[1:0]),
        .a     (rfile_rd1Pipe),
        .b     (rfile_rd2Pipe),
        .hi_we (mt_op_s & ~ex_stall & (funct_s == F_MTHI)),
        .lo_we (mt_op_s & ~ex_stall & (funct_s == F_MTLO)),
        .wdata (rfile_rd1Pipe),
        .busy  (busy_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // ALU and R-type funct decode; unknown functs and mult/div/mt* produce 0.
    always_comb begin
        result_s = {DATA_W{1'b0}};
        case (ALUOpPipe)
            ALUOP_ADD, ALUOP_ADD2: result_s = rfile_rd1Pipe + op_b_s;
            ALUOP_SUB:             result_s = rfile_rd1Pipe - op_b_s;
            ALUOP_RTYPE: begin
                case (funct_s)
                    F_ADD, F_ADDU: result_s = rfile_rd1Pipe + op_b_s;
                    F_SUB, F_SUBU: result_s = rfile_rd1Pipe - op_b_s;
                    F_AND:   result_s = rfile_rd1Pipe & op_b_s;
                    F_OR:    result_s = rfile_rd1Pipe | op_b_s;
                    F_XOR:   result_s = rfile_rd1Pipe ^ op_b_s;
                    F_NOR:   result_s = ~(rfile_rd1Pipe | op_b_s);
                    F_SLT:   result_s = {{(DATA_W-1){1'b0}}, ($signed(rfile_rd1Pipe) < $signed(op_b_s))};
                    F_SLTU:  result_s = {{(DATA_W-1){1'b0}}, (rfile_rd1Pipe < op_b_s)};
                    F_SLL:   result_s = rfile_rd2Pipe << shamt_s;
                    F_SRL:   result_s = rfile_rd2Pipe >> shamt_s;
                    F_SRA:   result_s = $unsigned($signed(rfile_rd2Pipe) >>> shamt_s);
                    F_MFHI:  result_s = hi_s;
                    F_MFLO:  result_s = lo_s;
                    default: result_s = {DATA_W{1'b0}};
                endcase
            end
            default: result_s = {DATA_W{1'b0}};
        endcase
    end

    assign alu_result    = result_s;
    assign alu_zero      = (result_s == {DATA_W{1'b0}});
    assign write_reg     = RegDstPipe ? rdPipe : rtPipe;
    assign store_data    = rfile_rd2Pipe;
    assign branch_target = pc_plus4 + {extend_immedPipe[DATA_W-3:0], 2'b00};

endmodule
